// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP issue controller.
package fpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 5;
  localparam int unsigned RD_W = 5;

  typedef enum logic [OP_W-1:0] {
    FLW, FSW, FADD, FSUB, FMUL, FDIV, FSQRT, FSGNJ,
    FSGNJN, FSGNJX, FCVTWS, FMVXW, FEQ, FLE, FCVTSW, FMVWX
  } fpu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    HOLD
  } ctrl_state_t;

  localparam logic [XLEN-1:0] FPU_CANON_NAN = 32'h7FC0_0000;

  // Ops whose completion is signalled by unit_done instead of a fixed one-cycle latency.
  function automatic logic is_multicycle(input fpu_op_t op);
    case (op)
      FADD, FSUB, FDIV, FSQRT: is_multicycle = 1'b1;
      default:                 is_multicycle = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// Cycle counter that flags when a multi-cycle op has waited TIMEOUT_CYC cycles.
module fpu_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             expire_q;
  logic             expire_d;

  // Clear takes priority; the owner stops counting once expire is seen, so no wrap.
  always_comb begin
    count_d  = count_q;
    expire_d = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = count_q + CNT_W'(1);
    end
    expire_d = (count_d == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Counter and registered expiry flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one FP op at a time to the shared FPU and returns its result to writeback.
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        req_fdst,
  output logic        unit_start,
  output logic [4:0]  unit_op,
  output logic [31:0] unit_x1,
  output logic [31:0] unit_x2,
  output logic        unit_flush,
  input  logic        unit_done,
  input  logic [31:0] unit_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_rd,
  output logic        resp_fdst,
  output logic        resp_err,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic        pend_fdst
);

  import fpu_pkg::*;

  ctrl_state_t     state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0] x1_q, x1_d;
  logic [XLEN-1:0] x2_q, x2_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            fdst_q, fdst_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;

  logic accept;
  logic wd_clear;
  logic wd_count;
  logic wd_expire;

  fpu_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (wd_clear),
    .count_en_i (wd_count),
    .expire_o   (wd_expire)
  );

  // Next-state, operand capture, result capture and watchdog control.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    rd_d       = rd_q;
    fdst_d     = fdst_q;
    result_d   = result_q;
    err_d      = err_q;
    wd_clear   = 1'b0;
    wd_count   = 1'b0;
    unit_flush = 1'b0;

    // Ready is masked during reset so nothing is accepted while the block is held.
    req_ready = !rst && ((state_q == IDLE) || ((state_q == HOLD) && resp_ready));
    accept    = req_valid && req_ready;

    if (accept) begin
      op_d   = req_op;
      x1_d   = req_rs1;
      x2_d   = req_rs2;
      rd_d   = req_rd;
      fdst_d = req_fdst;
      err_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (is_multicycle(fpu_op_t'(op_q))) begin
          wd_clear = 1'b1;
          state_d  = WAIT;
        end else begin
          result_d = unit_result;
          state_d  = HOLD;
        end
      end
      WAIT: begin
        // A completion in the expiry cycle beats the watchdog.
        if (unit_done) begin
          result_d = unit_result;
          state_d  = HOLD;
        end else if (wd_expire) begin
          unit_flush = 1'b1;
          err_d      = 1'b1;
          result_d   = FPU_CANON_NAN;
          state_d    = HOLD;
        end else begin
          wd_count = 1'b1;
        end
      end
      HOLD: begin
        if (resp_ready) state_d = accept ? LAUNCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      rd_q     <= '0;
      fdst_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      rd_q     <= rd_d;
      fdst_q   <= fdst_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign unit_start  = (state_q == LAUNCH);
  assign unit_op     = op_q;
  assign unit_x1     = x1_q;
  assign unit_x2     = x2_q;
  assign resp_valid  = (state_q == HOLD);
  assign resp_result = result_q;
  assign resp_rd     = rd_q;
  assign resp_fdst   = fdst_q;
  assign resp_err    = err_q;
  assign pend_valid  = (state_q != IDLE);
  assign pend_rd     = rd_q;
  assign pend_fdst   = fdst_q;

endmodule
